rr_grant_scheduler: RTL and testbench

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

---
 rtl/rr_grant_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_rr_grant_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
//
// rr_grant_scheduler
// ------------------
// Three-requester round-robin grant scheduler built around a small
// IDLE / GRANT / GAP state machine. A grant is held while its owner keeps
// requesting. Every release goes through a single-cycle GAP with all grants
// low. The next owner is chosen round-robin, starting after the
// last-served requester.
//
// Optional feature (compile-time macro HOLD_TIMEOUT_EN):
//   When defined, a grant that has lasted HOLD_MAX cycles is force-released
//   into GAP. `expired` pulses during that GAP cycle. When undefined, grants
//   are held indefinitely, `expired` is tied low and no hold counter exists.
//
// Parameters:
//   HOLD_MAX  maximum consecutive GRANT cycles (2..255), timeout build only
//
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   synchronous active-low reset
//   r[3:1]   in   request vector, r[i] = requester i wants the resource
//   g[3:1]   out  grant vector, one-hot or zero, decoded from registered state
//   busy     out  high while in GRANT
//   expired  out  one-cycle pulse in the GAP that follows a timeout release
//
module rr_grant_scheduler #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:1] r,
    output logic [3:1] g,
    output logic       busy,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_e;

    // Elaboration-time guard on the hold limit.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_grant_scheduler: HOLD_MAX must be within 2..255");
    end

    // Kept as a plain vector so the unused encoding 2'b11 is representable
    // and can be recovered from.
    logic [1:0] state_r;
    logic [1:0] owner_r;   // requester index 1..3 currently granted
    logic [1:0] ptr_r;     // last-served requester index 1..3

`ifdef HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_SAT  = 8'(HOLD_MAX);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_r;   // GRANT cycles elapsed, 0 on the first one
    logic       expired_r;
    logic       timeout_s;
`endif

    logic [3:1] owner_oh_s;
    logic       owner_req_s;
    logic       req_any_s;
    logic [1:0] pick_s;

    // Index 1..3 to one-hot grant vector; any other index gives no grant.
    function automatic logic [3:1] idx_to_onehot(input logic [1:0] idx);
        logic [3:1] oh;
        case (idx)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin pick: search last+1, last+2, last+3 with wrap 3->1.
    // Returns 0 when nothing is requested.
    function automatic logic [1:0] rr_pick(input logic [3:1] req,
                                           input logic [1:0] last);
        logic [1:0] first_idx;
        logic [1:0] second_idx;
        logic [1:0] third_idx;
        logic [1:0] pick;
        case (last)
            2'd1: begin
                first_idx  = 2'd2;
                second_idx = 2'd3;
                third_idx  = 2'd1;
            end
            2'd2: begin
                first_idx  = 2'd3;
                second_idx = 2'd1;
                third_idx  = 2'd2;
            end
            default: begin
                first_idx  = 2'd1;
                second_idx = 2'd2;
                third_idx  = 2'd3;
            end
        endcase
        if (|(req & idx_to_onehot(first_idx))) begin
            pick = first_idx;
        end else if (|(req & idx_to_onehot(second_idx))) begin
            pick = second_idx;
        end else if (|(req & idx_to_onehot(third_idx))) begin
            pick = third_idx;
        end else begin
            pick = 2'd0;
        end
        return pick;
    endfunction

    assign owner_oh_s  = idx_to_onehot(owner_r);
    assign owner_req_s = |(r & owner_oh_s);
    assign req_any_s   = |r;
    assign pick_s      = rr_pick(r, ptr_r);

`ifdef HOLD_TIMEOUT_EN
    // Counter reads HOLD_MAX-1 during the HOLD_MAX-th GRANT cycle.
    assign timeout_s = (hold_cnt_r >= HOLD_LAST);
    assign expired   = expired_r;
`else
    assign expired   = 1'b0;
`endif

    // Output decode from registered state only; illegal encodings grant nothing.
    always_comb begin
        g    = 3'b000;
        busy = 1'b0;
        if (state_r == GRANT) begin
            g    = owner_oh_s;
            busy = 1'b1;
        end else begin
            g    = 3'b000;
            busy = 1'b0;
        end
    end

    // Scheduler state machine: state, owner, round-robin pointer, hold timer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            owner_r    <= 2'd0;
            ptr_r      <= 2'd3;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt_r <= 8'd0;
            expired_r  <= 1'b0;
`endif
        end else begin
`ifdef HOLD_TIMEOUT_EN
            expired_r <= 1'b0;
`endif
            case (state_r)
                IDLE, GAP: begin
                    if (req_any_s) begin
                        state_r    <= GRANT;
                        owner_r    <= pick_s;
`ifdef HOLD_TIMEOUT_EN
                        hold_cnt_r <= 8'd0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req_s) begin
                        // Voluntary release; GAP arbitrates with this new ptr.
                        state_r <= GAP;
                        ptr_r   <= owner_r;
`ifdef HOLD_TIMEOUT_EN
                    end else if (timeout_s) begin
                        state_r   <= GAP;
                        ptr_r     <= owner_r;
                        expired_r <= 1'b1;
`endif
                    end else begin
                        state_r <= GRANT;
                    end
`ifdef HOLD_TIMEOUT_EN
                    if (hold_cnt_r != HOLD_SAT) begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
`endif
                end
                default: begin
                    // Unused encoding: recover to IDLE, pointer untouched.
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
//
// Directed bench for rr_grant_scheduler: a vector table covering reset,
// round-robin order, release/GAP behaviour and reset priority, followed by
// hand-written multi-cycle sequences (long hold or timeout, illegal state).
//
module tb_rr_grant_scheduler;

    logic       clk;
    logic       resetn;
    logic [3:1] r;
    logic [3:1] g;
    logic       busy;
    logic       expired;

    int checks = 0;
    int errors = 0;

    rr_grant_scheduler #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .r       (r),
        .g       (g),
        .busy    (busy),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        logic [3:1] req;
        logic [3:1] exp_g;
        logic       exp_busy;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    task automatic chk(input string nm, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int idx,
                           input logic [3:1] eg, input logic eb, input logic ee);
        chk({nm, "_g"},       idx, {1'b0, g},       {1'b0, eg});
        chk({nm, "_busy"},    idx, {3'b000, busy},    {3'b000, eb});
        chk({nm, "_expired"}, idx, {3'b000, expired}, {3'b000, ee});
    endtask

    logic [3:1] illegal_exp_g;

    initial begin
        //          resetn  r        g        busy
        tbl[0]  = '{1'b0, 3'b000, 3'b000, 1'b0};  // reset
        tbl[1]  = '{1'b0, 3'b111, 3'b000, 1'b0};  // reset beats requests
        tbl[2]  = '{1'b1, 3'b111, 3'b001, 1'b1};  // ptr=3 -> r1 first
        tbl[3]  = '{1'b1, 3'b111, 3'b001, 1'b1};  // hold
        tbl[4]  = '{1'b1, 3'b110, 3'b000, 1'b0};  // drop r1 -> GAP, ptr=1
        tbl[5]  = '{1'b1, 3'b110, 3'b010, 1'b1};  // r2 next
        tbl[6]  = '{1'b1, 3'b100, 3'b000, 1'b0};  // drop r2 -> GAP, ptr=2
        tbl[7]  = '{1'b1, 3'b101, 3'b100, 1'b1};  // order 3,1,2 -> r3
        tbl[8]  = '{1'b1, 3'b111, 3'b100, 1'b1};  // other changes ignored
        tbl[9]  = '{1'b1, 3'b011, 3'b000, 1'b0};  // drop r3 -> GAP, ptr=3
        tbl[10] = '{1'b1, 3'b011, 3'b001, 1'b1};  // order 1,2,3 -> r1
        tbl[11] = '{1'b0, 3'b011, 3'b000, 1'b0};  // reset mid-grant
        tbl[12] = '{1'b1, 3'b000, 3'b000, 1'b0};  // IDLE
        tbl[13] = '{1'b1, 3'b100, 3'b100, 1'b1};  // lone r3
        tbl[14] = '{1'b1, 3'b000, 3'b000, 1'b0};  // toggle low -> GAP
        tbl[15] = '{1'b1, 3'b100, 3'b100, 1'b1};  // r3 again
        tbl[16] = '{1'b1, 3'b000, 3'b000, 1'b0};  // GAP
        tbl[17] = '{1'b1, 3'b000, 3'b000, 1'b0};  // IDLE
        tbl[18] = '{1'b1, 3'b010, 3'b010, 1'b1};  // lone r2
        tbl[19] = '{1'b1, 3'b000, 3'b000, 1'b0};  // GAP, ptr=2
        tbl[20] = '{1'b1, 3'b100, 3'b100, 1'b1};  // r3 granted
        tbl[21] = '{1'b0, 3'b101, 3'b000, 1'b0};  // reset during g=100
        tbl[22] = '{1'b1, 3'b101, 3'b001, 1'b1};  // ptr back to 3 -> r1
        tbl[23] = '{1'b1, 3'b000, 3'b000, 1'b0};  // GAP, ptr=1
        tbl[24] = '{1'b1, 3'b000, 3'b000, 1'b0};  // IDLE

        resetn = 1'b0;
        r      = 3'b000;

        for (int i = 0; i < NVEC; i++) begin
            resetn = tbl[i].rn;
            r      = tbl[i].req;
            step();
            chk_out("vec", i, tbl[i].exp_g, tbl[i].exp_busy, 1'b0);
        end

`ifndef HOLD_TIMEOUT_EN
        // Long hold with no timeout: ptr=1 so r2 wins and keeps the grant.
        r = 3'b010;
        for (int c = 0; c < 20; c++) begin
            step();
            chk_out("hold20", c, 3'b010, 1'b1, 1'b0);
        end
        r = 3'b000;
        step();
        chk_out("hold20_gap", 0, 3'b000, 1'b0, 1'b0);
        step();
        chk_out("hold20_idle", 0, 3'b000, 1'b0, 1'b0);
        illegal_exp_g = 3'b100;   // ptr=2 -> r3 first
`else
        // Timeout with HOLD_MAX=4 and r=011 held from reset.
        resetn = 1'b0;
        r      = 3'b011;
        step();
        chk_out("to_reset", 0, 3'b000, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int c = 0; c < 11; c++) begin
            logic [3:1] eg;
            logic       eb;
            logic       ee;
            if (c < 4) begin
                eg = 3'b001; eb = 1'b1; ee = 1'b0;
            end else if (c == 4 || c == 9) begin
                eg = 3'b000; eb = 1'b0; ee = 1'b1;
            end else if (c < 9) begin
                eg = 3'b010; eb = 1'b1; ee = 1'b0;
            end else begin
                eg = 3'b001; eb = 1'b1; ee = 1'b0;
            end
            step();
            chk_out("timeout", c, eg, eb, ee);
        end
        r = 3'b000;
        step();
        chk_out("timeout_gap", 0, 3'b000, 1'b0, 1'b0);
        step();
        chk_out("timeout_idle", 0, 3'b000, 1'b0, 1'b0);
        illegal_exp_g = 3'b010;   // ptr=1 -> r2 first
`endif

        // Illegal state encoding, forced while idle with no requests.
        force dut.state_r = 2'b11;
        #1;
        chk_out("illegal", 0, 3'b000, 1'b0, 1'b0);
        #1;
        release dut.state_r;
        step();
        chk_out("illegal_next", 0, 3'b000, 1'b0, 1'b0);
        chk("illegal_state", 0, {2'b00, dut.state_r}, 4'b0000);
        r = 3'b111;
        step();
        chk_out("illegal_resume", 0, illegal_exp_g, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
